mdu_div_sequencer: RTL
======================

# mdu_div_sequencer

Sequencer and interlock controller for the pipelined core's multi-cycle `divu` unit and its HiLo register pair. It sits beside the ID/EX and EX/MEM stages and watches for a `divu` reaching EX. It then launches the divider, counts its latency and issues the single HiLo write. Until HiLo is valid it stalls the front end (PC, IF/ID) and injects bubbles into ID/EX for any dependent `mfhi`/`mflo` or a second `divu`.

## Interface
- `DIV_CYCLES`, default 32: divider latency in cycles from `div_start` to result valid. Legal range is 1 to 2**CNT_W-1.
- `CNT_W`, default 6: latency counter width.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `ex_div_valid  in  1`: a `divu` is in EX this cycle, with operands valid on the ID/EX outputs.
- `id_is_div  in  1`: the ID stage holds a `divu`.
- `id_is_mfhilo  in  1`: the ID stage holds an `mfhi` or `mflo`.
- `div_start  out  1`: one-cycle pulse that makes the divider latch its operands.
- `div_busy  out  1`: the divider is running, or the HiLo write is pending.
- `hilo_we  out  1`: one-cycle pulse that makes HiLo capture the divider result.
- `stall  out  1`: hold PC and IF/ID (drive `en_reg` low).
- `bubble  out  1`: load a NOP (all control fields zero) into ID/EX.
- `stall_cycles  out  32`: saturating count of cycles with `stall`=1.

## Operation
- **FSM states:** IDLE, RUN, WRITE. Reset state is IDLE.
- **IDLE:**
  - If `ex_div_valid`=1: assert `div_start` this cycle, load the counter with DIV_CYCLES, and go to RUN.
  - Otherwise stay in IDLE.
- **RUN:**
  - Decrement the counter by 1 each cycle.
  - When the counter equals 1, go to WRITE, so RUN lasts exactly DIV_CYCLES cycles.
  - `ex_div_valid` is ignored in RUN; the interlock guarantees it is 0.
- **WRITE:** assert `hilo_we` for exactly one cycle, then return to IDLE.
- **div_busy:** 1 in RUN and WRITE, 0 in IDLE.
- **Hazard condition:** `hz = (state != IDLE) | ex_div_valid`.
- **Stall equation:** `stall = bubble = hz & (id_is_div | id_is_mfhilo)`.
  - Both outputs are combinational from the state and the inputs.
  - An instruction in ID that is not a div or mfhilo never stalls.
- **Back-to-back divu:** the second `divu` is held in ID until the cycle in which the FSM is IDLE and no `divu` is in EX. It then advances and starts a fresh sequence.
- **stall_cycles:**
  - Increments by 1 on every clock edge where `stall`=1.
  - Saturates at 0xFFFF_FFFF; it never wraps.
- **Reset:**
  - `rst`=0 at any time, including mid-RUN, forces IDLE, counter 0 and `stall_cycles` 0, asynchronously.
  - While `rst`=0, all outputs are forced to 0, including `stall` and `bubble`.
  - An interrupted division never produces `hilo_we`.

## Timing
- Latency: `div_start` occurs in cycle T (the `divu` is in EX). RUN spans T+1 to T+DIV_CYCLES, `hilo_we` occurs in T+DIV_CYCLES+1, and IDLE resumes at T+DIV_CYCLES+2.
- `mfhi`/`mflo` in ID during cycle T: stalled T to T+DIV_CYCLES+1, then released at T+DIV_CYCLES+2. It reads HiLo in EX one cycle later, after the write has landed.
- Dependent instruction with DIV_CYCLES=32: exactly 34 stall cycles.
- `hilo_we` and `div_start` are never asserted in the same cycle.
- `stall_cycles` updates one edge after the stalled cycle.

## Test plan
- **Reset values:** hold `rst`=0 with all inputs =1. Required: all outputs 0, `stall_cycles`=0. Release `rst` with `ex_div_valid`=0: `stall`=0.
- **Single divu, no dependents:**
  - Stimulus: pulse `ex_div_valid` in cycle 10, DIV_CYCLES=32.
  - Required: `div_start` in cycle 10 only, `div_busy` in cycles 11–43, `hilo_we` in cycle 43 only, `stall` never asserted.
- **divu then mfhi:**
  - Stimulus: `ex_div_valid` in cycle 10, `id_is_mfhilo` held from cycle 10.
  - Required: `stall`=`bubble`=1 in cycles 10–43 (34 cycles), 0 in cycle 44, `stall_cycles`=34.
- **Back-to-back divu:**
  - Stimulus: `ex_div_valid` in cycle 5, `id_is_div` held from cycle 5. Drive `ex_div_valid` again in the first cycle after `stall` drops (cycle 39).
  - Required: a second `div_start` in cycle 39 and a second `hilo_we` in cycle 72.
- **Reset mid-RUN:**
  - Stimulus: start a division in cycle 10, pulse `rst`=0 during cycle 20.
  - Required: `div_busy`=0 immediately and `hilo_we` never asserted. A new `ex_div_valid` after release starts a clean 32-cycle sequence.
- **Boundary DIV_CYCLES=1 and saturation:**
  - With DIV_CYCLES=1: `div_start` in cycle T, RUN in T+1, `hilo_we` in T+2.
  - Force `stall_cycles` near 0xFFFF_FFFF (or use a test build with a narrow counter) and hold `stall` high. Required: the count holds at the maximum and does not wrap.

Source files
------------

// File: rtl/mdu_div_sequencer.sv
// Sequencer and interlock for the multi-cycle divu unit and its HiLo register pair.
// Launches the divider when a divu reaches EX, counts its latency, issues the single
// HiLo write, and holds dependent mfhi/mflo or a second divu in ID until HiLo is valid.
module mdu_div_sequencer #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6,
  // Width of the stall statistics counter; narrow builds make saturation observable.
  parameter int unsigned STALL_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_div_valid,
  input  logic               id_is_div,
  input  logic               id_is_mfhilo,
  output logic               div_start,
  output logic               div_busy,
  output logic               hilo_we,
  output logic               stall,
  output logic               bubble,
  output logic [STALL_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWrite
  } state_e;

  localparam logic [CNT_W-1:0]   CntLoad  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);
  localparam logic [STALL_W-1:0] StallMax = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] StallOne = STALL_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               hz;
  logic               dep_in_id;

  // FSM state and latency counter; reset abandons any division in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter update and the start/write pulses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_start = 1'b0;
    hilo_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // rst gates the pulse so nothing leaks out combinationally during reset.
        if (rst && ex_div_valid) begin
          div_start = 1'b1;
          cnt_d     = CntLoad;
          state_d   = StRun;
        end
      end
      StRun: begin
        // Counter enters RUN at DIV_CYCLES, so reaching 1 marks the last RUN cycle.
        if (cnt_q == CntOne) begin
          cnt_d   = '0;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StWrite: begin
        hilo_we = 1'b1;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Interlock: any div or HiLo reader in ID waits while a division is live or starting.
  always_comb begin
    div_busy  = (state_q != StIdle);
    hz        = div_busy | ex_div_valid;
    dep_in_id = id_is_div | id_is_mfhilo;
    stall     = rst & hz & dep_in_id;
    bubble    = stall;
  end

  // Saturating stall-cycle count; holds at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != StallMax)) begin
      stall_cnt_d = stall_cnt_q + StallOne;
    end
  end

  // Stall statistics register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule
